// File: rtl/aclk_time_counter_gen.sv
// BCD hh:mm time-of-day counter advanced by a prescaled tick, 24h or 12h (AM/PM) format.
// Optional build macro ACLK_LOAD_CHECK_EN: reject out-of-range loads and pulse load_err.
module aclk_time_counter_gen #(
    parameter int FORMAT_24H = 1,
    parameter int TICK_DIV   = 1,
    parameter int DIV_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       hold,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    input  logic       new_pm,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       pm,
    output logic       minute_pulse,
    output logic       day_wrap,
    output logic       load_err
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0]       RST_MS_HR  = (FORMAT_24H != 0) ? 4'd0 : 4'd1;
    localparam logic [3:0]       RST_LS_HR  = (FORMAT_24H != 0) ? 4'd0 : 4'd2;

    logic [3:0]       ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
    logic [3:0]       ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
    logic             pm_q, pm_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             minute_pulse_q, minute_pulse_d;
    logic             day_wrap_q, day_wrap_d;

    logic [3:0]       adv_ms_hr, adv_ls_hr, adv_ms_min, adv_ls_min;
    logic             adv_pm, adv_wrap;
    logic             load_ok;

`ifdef ACLK_LOAD_CHECK_EN
    logic load_err_q;

    always_comb begin
        load_ok = (new_current_time_ls_min <= 4'd9) && (new_current_time_ms_min <= 4'd5)
                  && (new_current_time_ls_hr <= 4'd9);
        if (FORMAT_24H != 0) begin
            load_ok = load_ok && ((new_current_time_ms_hr <= 4'd1) ||
                      ((new_current_time_ms_hr == 4'd2) && (new_current_time_ls_hr <= 4'd3)));
        end else begin
            load_ok = load_ok &&
                      (((new_current_time_ms_hr == 4'd0) && (new_current_time_ls_hr >= 4'd1)) ||
                       ((new_current_time_ms_hr == 4'd1) && (new_current_time_ls_hr <= 4'd2)));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) load_err_q <= 1'b0;
        else       load_err_q <= load_new_c && !load_ok;
    end

    assign load_err = load_err_q;
`else
    assign load_ok  = 1'b1;
    assign load_err = 1'b0;
`endif

    // One-minute advance; >= compares let out-of-range digits roll back into range.
    always_comb begin
        adv_ls_min = ls_min_q + 4'd1;
        adv_ms_min = ms_min_q;
        adv_ls_hr  = ls_hr_q;
        adv_ms_hr  = ms_hr_q;
        adv_pm     = pm_q;
        adv_wrap   = 1'b0;
        if (ls_min_q >= 4'd9) begin
            adv_ls_min = 4'd0;
            if (ms_min_q >= 4'd5) begin
                adv_ms_min = 4'd0;
                if (FORMAT_24H != 0) begin
                    if ((ms_hr_q >= 4'd2) && (ls_hr_q >= 4'd3)) begin
                        adv_ms_hr = 4'd0;
                        adv_ls_hr = 4'd0;
                        adv_wrap  = 1'b1;
                    end else if (ls_hr_q >= 4'd9) begin
                        adv_ls_hr = 4'd0;
                        adv_ms_hr = ms_hr_q + 4'd1;
                    end else begin
                        adv_ls_hr = ls_hr_q + 4'd1;
                    end
                end else begin
                    if ((ms_hr_q == 4'd1) && (ls_hr_q == 4'd1)) begin
                        adv_ls_hr = 4'd2;
                        adv_pm    = ~pm_q;
                        adv_wrap  = pm_q;
                    end else if ((ms_hr_q >= 4'd1) && (ls_hr_q >= 4'd2)) begin
                        adv_ms_hr = 4'd0;
                        adv_ls_hr = 4'd1;
                    end else if (ls_hr_q >= 4'd9) begin
                        adv_ms_hr = 4'd1;
                        adv_ls_hr = 4'd0;
                    end else begin
                        adv_ls_hr = ls_hr_q + 4'd1;
                    end
                end
            end else begin
                adv_ms_min = ms_min_q + 4'd1;
            end
        end
    end

    always_comb begin
        ms_hr_d        = ms_hr_q;
        ls_hr_d        = ls_hr_q;
        ms_min_d       = ms_min_q;
        ls_min_d       = ls_min_q;
        pm_d           = pm_q;
        presc_d        = presc_q;
        minute_pulse_d = 1'b0;
        day_wrap_d     = 1'b0;
        if (load_new_c) begin
            if (load_ok) begin
                ms_hr_d  = new_current_time_ms_hr;
                ls_hr_d  = new_current_time_ls_hr;
                ms_min_d = new_current_time_ms_min;
                ls_min_d = new_current_time_ls_min;
                pm_d     = (FORMAT_24H != 0) ? 1'b0 : new_pm;
                presc_d  = '0;
            end
        end else if (tick && !hold) begin
            if (presc_q == PRESC_LAST) begin
                presc_d        = '0;
                ms_hr_d        = adv_ms_hr;
                ls_hr_d        = adv_ls_hr;
                ms_min_d       = adv_ms_min;
                ls_min_d       = adv_ls_min;
                pm_d           = adv_pm;
                minute_pulse_d = 1'b1;
                day_wrap_d     = adv_wrap;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_hr_q        <= RST_MS_HR;
            ls_hr_q        <= RST_LS_HR;
            ms_min_q       <= 4'd0;
            ls_min_q       <= 4'd0;
            pm_q           <= 1'b0;
            presc_q        <= '0;
            minute_pulse_q <= 1'b0;
            day_wrap_q     <= 1'b0;
        end else begin
            ms_hr_q        <= ms_hr_d;
            ls_hr_q        <= ls_hr_d;
            ms_min_q       <= ms_min_d;
            ls_min_q       <= ls_min_d;
            pm_q           <= pm_d;
            presc_q        <= presc_d;
            minute_pulse_q <= minute_pulse_d;
            day_wrap_q     <= day_wrap_d;
        end
    end

    assign current_time_ms_hr  = ms_hr_q;
    assign current_time_ls_hr  = ls_hr_q;
    assign current_time_ms_min = ms_min_q;
    assign current_time_ls_min = ls_min_q;
    assign pm                  = pm_q;
    assign minute_pulse        = minute_pulse_q;
    assign day_wrap            = day_wrap_q;

endmodule

// File: tb/tb_aclk_time_counter_gen.sv
// Bench for aclk_time_counter_gen: four instances (24h/12h, several prescale ratios)
// checked every cycle against a minutes-of-day reference model.
module tb_aclk_time_counter_gen;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick[N], hold[N], load[N], npm[N];
    logic [3:0] n_mh[N], n_lh[N], n_mm[N], n_lm[N];
    logic [3:0] c_mh[N], c_lh[N], c_mm[N], c_lm[N];
    logic       o_pm[N], o_mp[N], o_dw[N], o_le[N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        aclk_time_counter_gen #(
            .FORMAT_24H((g == 0 || g == 2) ? 1 : 0),
            .TICK_DIV  (g == 2 ? 60 : (g == 3 ? 3 : 1)),
            .DIV_W     (g == 3 ? 2 : 16)
        ) u_dut (
            .clk                    (clk),
            .reset                  (rst),
            .tick                   (tick[g]),
            .hold                   (hold[g]),
            .load_new_c             (load[g]),
            .new_current_time_ms_hr (n_mh[g]),
            .new_current_time_ls_hr (n_lh[g]),
            .new_current_time_ms_min(n_mm[g]),
            .new_current_time_ls_min(n_lm[g]),
            .new_pm                 (npm[g]),
            .current_time_ms_hr     (c_mh[g]),
            .current_time_ls_hr     (c_lh[g]),
            .current_time_ms_min    (c_mm[g]),
            .current_time_ls_min    (c_lm[g]),
            .pm                     (o_pm[g]),
            .minute_pulse           (o_mp[g]),
            .day_wrap               (o_dw[g]),
            .load_err               (o_le[g])
        );
    end

    always #5 clk = ~clk;

    // Reference model: time as minutes since midnight plus a tick counter.
    int         m[N], p[N];
    bit         mp[N], dw[N], le[N], raw[N];
    logic [15:0] raw_t[N];
    logic       raw_pm[N];
    int         errs = 0;
    int         checks = 0;

    function automatic bit is24(int i);
        return (i == 0 || i == 2);
    endfunction

    function automatic int div_of(int i);
        return (i == 2) ? 60 : ((i == 3) ? 3 : 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [19:0] dut_vec(int i);
        return {c_mh[i], c_lh[i], c_mm[i], c_lm[i], o_pm[i], o_mp[i], o_dw[i], o_le[i]};
    endfunction

    function automatic logic [19:0] exp_vec(int i);
        int   h, mn;
        logic pmv;
        if (raw[i]) return {raw_t[i], (is24(i) ? 1'b0 : raw_pm[i]), mp[i], dw[i], le[i]};
        h   = m[i] / 60;
        mn  = m[i] % 60;
        pmv = 1'b0;
        if (!is24(i)) begin
            pmv = (h >= 12);
            h   = h % 12;
            if (h == 0) h = 12;
        end
        return {4'(h / 10), 4'(h % 10), 4'(mn / 10), 4'(mn % 10), pmv, mp[i], dw[i], le[i]};
    endfunction

    function automatic bit load_valid(int i);
        int h;
        if (n_lm[i] > 4'd9 || n_mm[i] > 4'd5 || n_lh[i] > 4'd9) return 1'b0;
        h = int'(n_mh[i]) * 10 + int'(n_lh[i]);
        return is24(i) ? (h <= 23) : (h >= 1 && h <= 12);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m[i] = 0; p[i] = 0; mp[i] = 0; dw[i] = 0; le[i] = 0; raw[i] = 0;
        end
    endtask

    task automatic model_step();
        int h, mn;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            mp[i] = 0; dw[i] = 0; le[i] = 0;
            if (load[i]) begin
                if (load_valid(i)) begin
                    h  = int'(n_mh[i]) * 10 + int'(n_lh[i]);
                    mn = int'(n_mm[i]) * 10 + int'(n_lm[i]);
                    m[i]   = is24(i) ? (h * 60 + mn) : (((h % 12) + (npm[i] ? 12 : 0)) * 60 + mn);
                    p[i]   = 0;
                    raw[i] = 0;
                end else begin
`ifdef ACLK_LOAD_CHECK_EN
                    le[i] = 1;
`else
                    raw[i]    = 1;
                    raw_t[i]  = {n_mh[i], n_lh[i], n_mm[i], n_lm[i]};
                    raw_pm[i] = npm[i];
                    p[i]      = 0;
`endif
                end
            end else if (tick[i] && !hold[i]) begin
                if (p[i] == div_of(i) - 1) begin
                    p[i]  = 0;
                    mp[i] = 1;
                    if (m[i] == 1439) dw[i] = 1;
                    m[i] = (m[i] + 1) % 1440;
                end else begin
                    p[i]++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("cycle_u%0d", i), 32'(dut_vec(i)), 32'(exp_vec(i)));
            tick[i] = 1'b0;
            load[i] = 1'b0;
        end
    endtask

    task automatic set_load(input int i, input int mh, input int lh, input int mm, input int lm,
                            input logic pmv);
        load[i] = 1'b1;
        n_mh[i] = 4'(mh);
        n_lh[i] = 4'(lh);
        n_mm[i] = 4'(mm);
        n_lm[i] = 4'(lm);
        npm[i]  = pmv;
    endtask

    task automatic ticks(input int i, input int n);
        repeat (n) begin
            tick[i] = 1'b1;
            step();
        end
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < N; i++) check_eq($sformatf("async_rst_u%0d", i), 32'(dut_vec(i)), 32'(exp_vec(i)));
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int h, mn;
        for (int i = 0; i < N; i++) begin
            tick[i] = 0; hold[i] = 0; load[i] = 0; npm[i] = 0;
            n_mh[i] = 0; n_lh[i] = 0; n_mm[i] = 0; n_lm[i] = 0;
        end
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();

        // 24h midnight wrap
        set_load(0, 2, 3, 5, 9, 0); step();
        ticks(0, 1); step();

        // 12h noon / 1 o'clock / midnight transitions
        set_load(1, 1, 1, 5, 9, 0); step(); ticks(1, 1);
        set_load(1, 1, 2, 5, 9, 1); step(); ticks(1, 1);
        set_load(1, 1, 1, 5, 9, 1); step(); ticks(1, 1); step();

        // 60:1 prescaler: 59 ticks hold, 60th advances; then with held ticks in the middle
        set_load(2, 1, 0, 0, 0, 0); step();
        ticks(2, 59); ticks(2, 1);
        ticks(2, 29);
        hold[2] = 1'b1; ticks(2, 11); hold[2] = 1'b0;
        ticks(2, 30); ticks(2, 1);

        // load beats a concurrent tick and clears the prescaler
        ticks(2, 5);
        set_load(2, 0, 9, 5, 9, 0); tick[2] = 1'b1; step();
        ticks(2, 59); ticks(2, 1);

        // hold does not block a load
        hold[3] = 1'b1; set_load(3, 0, 7, 1, 5, 1); step(); ticks(3, 4); hold[3] = 1'b0;
        ticks(3, 7);

        // reset mid-count
        set_load(2, 1, 4, 3, 7, 0); step(); ticks(2, 25);
        set_load(3, 0, 2, 3, 7, 1); step(); ticks(3, 5);
        async_reset();
        step();

        // out-of-range loads
        set_load(0, 2, 4, 0, 0, 0);
        set_load(1, 0, 0, 3, 0, 0);
        step(); step();

        // back to known-valid values before random traffic
        for (int i = 0; i < N; i++) set_load(i, 1, 1, 5, 8, 1);
        step();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                hold[i] = ($urandom_range(0, 4) == 0);
                tick[i] = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 30) == 0) begin
                    h  = is24(i) ? int'($urandom_range(0, 23)) : int'($urandom_range(1, 12));
                    mn = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 59))
                                                      : 59 - int'($urandom_range(0, 2));
                    if (is24(i) && $urandom_range(0, 1) == 1) h = 23;
                    set_load(i, h / 10, h % 10, mn / 10, mn % 10, $urandom_range(0, 1) == 1);
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

endmodule
